mul_div_unit: RTL and testbench

//  Multi-cycle multiply/divide responder for the pipelined MIPS core; sits in EX beside the single-cycle ALU.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mul_div_unit.sv | 109 ++++++++++
 tb/tb_mul_div_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and
// default latencies together with the busy-counter width derived from them.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_MAX_CYCLES  = (MDU_MULT_CYCLES > MDU_DIV_CYCLES) ?
                                   MDU_MULT_CYCLES : MDU_DIV_CYCLES;
  localparam int MDU_CNT_W       = $clog2(MDU_MAX_CYCLES + 1);

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide responder: computes the 64-bit result at accept
// time into shadow registers, then commits it to HI/LO after a fixed latency.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // Handshake: a request is accepted on a rising edge where start=1 and
  // busy=0; any start seen while busy=1 is dropped, so requesters stall on start|busy.

  logic [MDU_CNT_W-1:0] counter;
  logic [31:0]          shadow_hi;
  logic [31:0]          shadow_lo;
  logic [31:0]          res_hi;
  logic [31:0]          res_lo;
  logic [63:0]          prod_s;
  logic [63:0]          prod_u;
  logic signed [31:0]   a_s;
  logic signed [31:0]   b_s;

  assign a_s    = A;
  assign b_s    = B;
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (mdu_op_e'(mdu_op))
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        if (B == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = A;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = a_s / b_s;
          res_hi = a_s % b_s;
        end
      end
      MDU_DIVU: begin
        if (B == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = A;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      counter   <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      HI        <= '0;
      LO        <= '0;
    end else if (busy) begin
      counter <= counter - 1'b1;
      if (counter == MDU_CNT_W'(1)) begin
        HI   <= shadow_hi;
        LO   <= shadow_lo;
        busy <= 1'b0;
      end
    end else if (start) begin
      case (mdu_op_e'(mdu_op))
        MDU_MULT, MDU_MULTU: begin
          shadow_hi <= res_hi;
          shadow_lo <= res_lo;
          counter   <= MDU_CNT_W'(MULT_CYCLES);
          busy      <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          shadow_hi <= res_hi;
          shadow_lo <= res_lo;
          counter   <= MDU_CNT_W'(DIV_CYCLES);
          busy      <= 1'b1;
        end
        MDU_MTHI: HI <= A;
        MDU_MTLO: LO <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed vectors for multiply, divide,
// special divide cases, mthi/mtlo, dropped requests while busy and async reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // driver: present a request for one edge, return 1ns after that edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Count edges after acceptance until busy drops; HI/LO must hold the old
  // values meanwhile, then equal the queued expected result.
  task automatic wait_idle(input string tag, input int n_exp, input int n_start,
                           input logic [31:0] old_hi, input logic [31:0] old_lo);
    int n;
    int bad_hold;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    n = n_start;
    bad_hold = 0;
    while (busy && n < 200) begin
      if (HI !== old_hi || LO !== old_lo) bad_hold++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'(n_exp));
    check({tag, "_hold"}, 32'(bad_hold), 32'd0);
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    check({tag, "_hi"}, HI, e_hi);
    check({tag, "_lo"}, LO, e_lo);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = HI;
    old_lo = LO;
    exp_q.push_back(e_hi);
    exp_q.push_back(e_lo);
    issue(op, a, b);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    wait_idle(tag, n_exp, 0, old_hi, old_lo);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    mdu_op   = 3'd0;
    A        = '0;
    B        = '0;

    // 1. reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // reset during a DIV aborts without a late commit
    issue(MDU_MTLO, 32'd5, 32'd0);
    check("pre_rst_lo", LO, 32'd5);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    // 2-3. multiply
    issue(MDU_MTHI, 32'h1111_1111, 32'd0);
    issue(MDU_MTLO, 32'h2222_2222, 32'd0);
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_big", MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001);

    // 4. divide, including divide by zero
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_zero", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 10, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu", MDU_DIVU, 32'hFFFF_FFFF, 32'd10, 10, 32'h0000_0005, 32'h1999_9999);

    // 5. signed overflow, with an MTLO dropped while busy
    begin
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      old_hi = HI;
      old_lo = LO;
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h8000_0000);
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(MDU_MTLO, 32'h0000_1234, 32'd0);
      check("ovf_mtlo_dropped", LO, old_lo);
      wait_idle("div_ovf", 10, 1, old_hi, old_lo);
    end

    // unused op code is ignored
    issue(3'd7, 32'hAAAA_AAAA, 32'd1);
    check("nop7_busy", 32'(busy), 32'd0);
    check("nop7_hi", HI, 32'h0000_0000);
    check("nop7_lo", LO, 32'h8000_0000);

    // 6. MTHI while idle, then MULT right after
    issue(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", HI, 32'hDEAD_BEEF);
    check("mthi_busy", 32'(busy), 32'd0);
    run_op("mult_after_mthi", MDU_MULT, 32'd6, 32'd7, 5, 32'h0000_0000, 32'h0000_002A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
